// File: rtl/bus_pkg.sv
// bus_pkg: shared bus geometry and source index map for the datapath bus.
//   BUS_W        default bus word width
//   NUM_BUS_SRC  default number of bus sources
//   SRC_*        drive_en bit / src_data slot assigned to each datapath source
package bus_pkg;
    localparam int BUS_W       = 32;
    localparam int NUM_BUS_SRC = 24;
    localparam int SRC_R0  = 0,  SRC_R1  = 1,  SRC_R2  = 2,  SRC_R3  = 3;
    localparam int SRC_R4  = 4,  SRC_R5  = 5,  SRC_R6  = 6,  SRC_R7  = 7;
    localparam int SRC_R8  = 8,  SRC_R9  = 9,  SRC_R10 = 10, SRC_R11 = 11;
    localparam int SRC_R12 = 12, SRC_R13 = 13, SRC_R14 = 14, SRC_R15 = 15;
    localparam int SRC_HI  = 16, SRC_LO  = 17, SRC_ZHI = 18, SRC_ZLO   = 19;
    localparam int SRC_PC  = 20, SRC_MDR = 21, SRC_PORT = 22, SRC_CSIGN = 23;
endpackage

// File: rtl/bus_prio_enc.sv
// bus_prio_enc: combinational priority encoder over the bus drive strobes.
//   i_req   in  N      drive strobes
//   o_idx   out SEL_W  lowest asserted index (0 when none)
//   o_any   out 1      at least one strobe asserted
//   o_multi out 1      more than one strobe asserted
module bus_prio_enc
    import bus_pkg::*;
#(
    parameter int N     = NUM_BUS_SRC,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any,
    output logic             o_multi
);
    // Scanning downward lets the lowest set index overwrite the others.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (i_req[i]) o_idx = SEL_W'(i);
    end
    assign o_any   = |i_req;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign o_multi = |(i_req & (i_req - N'(1)));
endmodule

// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered priority bus multiplexer with contention detection.
//   i_clock        in  1              rising-edge clock
//   i_clear        in  1              synchronous active-high reset
//   i_src_data     in  NUM_SRC*WIDTH  source i = i_src_data[i*WIDTH +: WIDTH]
//   i_drive_en     in  NUM_SRC        per-source drive strobes
//   i_err_clr      in  1              clears sticky contention flag
//   o_bus_out      out WIDTH          registered bus word
//   o_bus_valid    out 1              bus word loaded from a source this cycle
//   o_src_idx      out SEL_W          source that produced o_bus_out
//   o_contention   out 1              more than one strobe at the last edge
//   o_contention_s out 1              sticky contention flag
//   o_xfer_cnt     out CNT_W          valid transfers since reset (wraps)
module bus_mux_reg
    import bus_pkg::*;
#(
    parameter int WIDTH     = BUS_W,
    parameter int NUM_SRC   = NUM_BUS_SRC,
    parameter int SEL_W     = $clog2(NUM_SRC),
    parameter bit IDLE_ZERO = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic                     i_clock,
    input  logic                     i_clear,
    input  logic [NUM_SRC*WIDTH-1:0] i_src_data,
    input  logic [NUM_SRC-1:0]       i_drive_en,
    input  logic                     i_err_clr,
    output logic [WIDTH-1:0]         o_bus_out,
    output logic                     o_bus_valid,
    output logic [SEL_W-1:0]         o_src_idx,
    output logic                     o_contention,
    output logic                     o_contention_s,
    output logic [CNT_W-1:0]         o_xfer_cnt
);
    logic [SEL_W-1:0] w_idx;
    logic             w_any;
    logic             w_multi;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_bus;
    logic             r_valid;
    logic [SEL_W-1:0] r_idx;
    logic             r_cont;
    logic             r_cont_s;
    logic [CNT_W-1:0] r_cnt;

    bus_prio_enc #(.N(NUM_SRC), .SEL_W(SEL_W)) u_enc (
        .i_req   (i_drive_en),
        .o_idx   (w_idx),
        .o_any   (w_any),
        .o_multi (w_multi)
    );

    // Compare-and-select keeps the mux fully defined: no X for any index.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (w_idx == SEL_W'(i)) w_word = i_src_data[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_bus    <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_cont   <= 1'b0;
            r_cont_s <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_valid  <= w_any;
            r_cont   <= w_multi;
            // New contention beats a simultaneous clear request.
            r_cont_s <= w_multi | (r_cont_s & ~i_err_clr);
            if (w_any) begin
                r_bus <= w_word;
                r_idx <= w_idx;
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (IDLE_ZERO) begin
                r_bus <= '0;
            end
        end
    end

    assign o_bus_out      = r_bus;
    assign o_bus_valid    = r_valid;
    assign o_src_idx      = r_idx;
    assign o_contention   = r_cont;
    assign o_contention_s = r_cont_s;
    assign o_xfer_cnt     = r_cnt;
endmodule
